mult4_arb: RTL and testbench

Round-robin arbiter and sequencer that shares one combinational `mult4` 4x4 unsigned multiplier among `N_REQ` requesters. It accepts one operand pair at a time over a per-requester valid/ready handshake and drives the shared multiplier's `a`/`b` inputs from registers. It captures the 8-bit product after a fixed settle cycle and returns it to the winning requester over a per-requester response handshake. It sits between client blocks and the single `mult4` instance; the multiplier itself stays purely combinational.

---
 rtl/mult4_arb_if.sv | 24 ++
 rtl/mult4_arb.sv | 146 ++++++++++++++
 tb/tb_mult4_arb.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mult4_arb_if.sv
// Requester and multiplier bus of the shared 4x4 multiplier arbiter.
// master = requesters plus the external mult4 instance, slave = arbiter.
interface mult4_arb_if #(parameter int N_REQ = 4);
  logic [N_REQ-1:0]   req_valid;
  logic [N_REQ-1:0]   req_ready;
  logic [4*N_REQ-1:0] req_a;
  logic [4*N_REQ-1:0] req_b;
  logic [3:0]         mul_a;
  logic [3:0]         mul_b;
  logic [7:0]         mul_z;
  logic [N_REQ-1:0]   rsp_valid;
  logic [N_REQ-1:0]   rsp_ready;
  logic [7:0]         rsp_z;
  logic               busy;

  modport master (
    output req_valid, req_a, req_b, rsp_ready, mul_z,
    input  req_ready, rsp_valid, rsp_z, busy, mul_a, mul_b
  );
  modport slave (
    input  req_valid, req_a, req_b, rsp_ready, mul_z,
    output req_ready, rsp_valid, rsp_z, busy, mul_a, mul_b
  );
endinterface

// File: rtl/mult4_arb.sv
// Round-robin arbiter/sequencer sharing one combinational mult4 among N_REQ
// requesters: IDLE grants, CALC lets the product settle, RESP hands it back.
module mult4_arb_lane #(
  parameter int PW = 2,
  parameter int ID = 0
) (
  input  logic          idle,
  input  logic          found,
  input  logic          in_resp,
  input  logic [PW-1:0] win,
  input  logic [PW-1:0] own,
  input  logic          rsp_ready,
  output logic          req_ready,
  output logic          own_hit,
  output logic          rsp_fire
);
  assign own_hit   = (own == PW'(ID));
  assign req_ready = idle && found && (win == PW'(ID));
  assign rsp_fire  = in_resp && own_hit && rsp_ready;
endmodule

module mult4_arb #(
  parameter int N_REQ = 4
) (
  input logic        clk,
  input logic        rst_n,
  mult4_arb_if.slave bus
);
  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q, state_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic [PW-1:0]    own_q, own_d;
  logic [3:0]       mul_a_q, mul_a_d;
  logic [3:0]       mul_b_q, mul_b_d;
  logic [7:0]       rsp_z_q, rsp_z_d;
  logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic             busy_q, busy_d;

  logic [PW-1:0]    win, idx;
  logic             found, idle, in_resp;
  logic [N_REQ-1:0] req_ready, own_oh, rsp_fire;
  int               j;

  // Rotating-priority search starting at ptr, wrapping modulo N_REQ.
  always_comb begin
    found = 1'b0;
    win   = '0;
    j     = 0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      j = int'(ptr_q) + k;
      if (j >= N_REQ) j = j - N_REQ;
      idx = PW'(j);
      if (!found && bus.req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Grants are held off while reset is asserted so nothing leaks during reset.
  assign idle    = (state_q == IDLE) && rst_n;
  assign in_resp = (state_q == RESP);

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    mult4_arb_lane #(.PW(PW), .ID(i)) u_lane (
      .idle      (idle),
      .found     (found),
      .in_resp   (in_resp),
      .win       (win),
      .own       (own_q),
      .rsp_ready (bus.rsp_ready[i]),
      .req_ready (req_ready[i]),
      .own_hit   (own_oh[i]),
      .rsp_fire  (rsp_fire[i])
    );
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    own_d       = own_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    rsp_z_d     = rsp_z_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    case (state_q)
      IDLE: if (found) begin
        for (int i = 0; i < N_REQ; i++) begin
          if (win == PW'(i)) begin
            mul_a_d = bus.req_a[4*i +: 4];
            mul_b_d = bus.req_b[4*i +: 4];
          end
        end
        own_d   = win;
        state_d = CALC;
        busy_d  = 1'b1;
      end
      CALC: begin
        rsp_z_d     = bus.mul_z;
        rsp_valid_d = own_oh;
        state_d     = RESP;
      end
      RESP: if (|rsp_fire) begin
        ptr_d       = (own_q == PW'(N_REQ-1)) ? '0 : own_q + 1'b1;
        rsp_valid_d = '0;
        busy_d      = 1'b0;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      own_q       <= '0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      rsp_z_q     <= '0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      own_q       <= own_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      rsp_z_q     <= rsp_z_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_z     = rsp_z_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_mult4_arb.sv
// Bench for mult4_arb: vector table, directed corner sequences, and a
// randomized transaction-level reference model of the round-robin arbiter.
module tb_mult4_arb;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mult4_arb_if #(.N_REQ(4)) bus();
  mult4_arb #(.N_REQ(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  assign bus.mul_z = {4'b0, bus.mul_a} * {4'b0, bus.mul_b};

  mult4_arb_if #(.N_REQ(3)) bus3();
  mult4_arb #(.N_REQ(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  assign bus3.mul_z = {4'b0, bus3.mul_a} * {4'b0, bus3.mul_b};

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] z;
  } vec_t;
  vec_t tbl[5];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic clr();
    bus.req_valid  = '0; bus.req_a  = '0; bus.req_b  = '0; bus.rsp_ready  = '0;
    bus3.req_valid = '0; bus3.req_a = '0; bus3.req_b = '0; bus3.rsp_ready = '0;
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr();
    step(); step(); #1;
    rst_n = 1'b1;
  endtask

  // Single isolated transaction with a non-owner rsp_ready pulse in RESP.
  task automatic run_vec(input vec_t v);
    int oh;
    oh = 1 << v.idx;
    step();
    bus.req_valid = 4'(oh);
    bus.req_a = '0; bus.req_b = '0;
    bus.req_a[4*v.idx +: 4] = v.a;
    bus.req_b[4*v.idx +: 4] = v.b;
    #1;
    chk("vec_grant", 32'(bus.req_ready), oh);
    chk("vec_idle_busy", 32'(bus.busy), 0);
    step();
    bus.req_valid = '0;
    #1;
    chk("vec_calc_busy", 32'(bus.busy), 1);
    chk("vec_calc_rspv", 32'(bus.rsp_valid), 0);
    chk("vec_mul_a", 32'(bus.mul_a), 32'(v.a));
    chk("vec_mul_b", 32'(bus.mul_b), 32'(v.b));
    step();
    bus.rsp_ready = 4'(oh ^ 'hF);
    #1;
    chk("vec_rspv", 32'(bus.rsp_valid), oh);
    chk("vec_rsp_z", 32'(bus.rsp_z), 32'(v.z));
    step();
    bus.rsp_ready = 4'(oh);
    #1;
    chk("vec_nonowner_hold", 32'(bus.rsp_valid), oh);
    chk("vec_nonowner_z", 32'(bus.rsp_z), 32'(v.z));
    step();
    bus.rsp_ready = '0;
    #1;
    chk("vec_done_busy", 32'(bus.busy), 0);
    chk("vec_done_rspv", 32'(bus.rsp_valid), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    int order[5];
    int prod[5];
    int n;
    int ptr_m, w, a_m, b_m, pending;
    logic [3:0] ra[4];
    logic [3:0] rb[4];
    bit         v[4];
    logic [3:0] rr;

    tbl[0] = '{2, 4'hF, 4'hF, 8'hE1};
    tbl[1] = '{0, 4'h0, 4'hF, 8'h00};
    tbl[2] = '{3, 4'h3, 4'h5, 8'h0F};
    tbl[3] = '{1, 4'h8, 4'h2, 8'h10};
    tbl[4] = '{2, 4'hA, 4'hC, 8'h78};
    order = '{0, 1, 2, 3, 0};
    prod  = '{3, 6, 9, 12, 3};

    // Fairness: all requesters valid from reset.
    rst_n = 1'b0;
    clr();
    bus.req_valid = 4'hF;
    bus.req_a = 16'h4321;
    bus.req_b = 16'h3333;
    bus.rsp_ready = 4'hF;
    step(); step(); #1;
    chk("rst_req_ready", 32'(bus.req_ready), 0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 0);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_mul_a", 32'(bus.mul_a), 0);
    chk("rst_mul_b", 32'(bus.mul_b), 0);
    chk("rst_rsp_z", 32'(bus.rsp_z), 0);
    rst_n = 1'b1;
    #1;
    for (int t = 0; t < 5; t++) begin
      n = 0;
      while (bus.req_ready == '0 && n < 10) begin step(); #1; n++; end
      chk("fair_grant", 32'(bus.req_ready), 1 << order[t]);
      n = 0;
      while (bus.rsp_valid == '0 && n < 10) begin step(); #1; n++; end
      chk("fair_rspv", 32'(bus.rsp_valid), 1 << order[t]);
      chk("fair_prod", 32'(bus.rsp_z), prod[t]);
    end

    // Table-driven single transactions.
    do_reset();
    for (int i = 0; i < 5; i++) run_vec(tbl[i]);

    // Backpressure with a competing request from requester 0.
    step();
    bus.req_valid = 4'b0010;
    bus.req_a = 16'h0070; bus.req_b = 16'h0090;
    #1;
    chk("bp_grant1", 32'(bus.req_ready), 2);
    step();
    bus.req_valid = 4'b0001;
    bus.req_a = 16'h0001; bus.req_b = 16'h0001;
    #1;
    chk("bp_calc_noready", 32'(bus.req_ready), 0);
    for (int c = 0; c < 5; c++) begin
      step();
      bus.rsp_ready = (c == 2) ? 4'b1101 : 4'b0000;
      #1;
      chk("bp_rspv", 32'(bus.rsp_valid), 2);
      chk("bp_rsp_z", 32'(bus.rsp_z), 'h3F);
      chk("bp_req_ready", 32'(bus.req_ready), 0);
    end
    step();
    bus.rsp_ready = 4'b0010;
    #1;
    chk("bp_still_resp", 32'(bus.rsp_valid), 2);
    step();
    bus.rsp_ready = '0;
    #1;
    chk("bp_grant0", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = '0;
    step();
    bus.rsp_ready = 4'b0001;
    #1;
    chk("bp_r0_rspv", 32'(bus.rsp_valid), 1);
    chk("bp_r0_z", 32'(bus.rsp_z), 1);
    step();
    bus.rsp_ready = '0;

    // Reset in CALC; ptr is 1 here, so a 0/3 pair distinguishes a cleared ptr.
    bus.req_valid = 4'b1000;
    bus.req_a = 16'h5000; bus.req_b = 16'h5000;
    #1;
    chk("rmid_grant", 32'(bus.req_ready), 8);
    step();
    bus.req_valid = '0;
    rst_n = 1'b0;
    #1;
    chk("rmid_calc_busy", 32'(bus.busy), 1);
    step();
    rst_n = 1'b1;
    #1;
    chk("rmid_busy", 32'(bus.busy), 0);
    chk("rmid_rspv", 32'(bus.rsp_valid), 0);
    chk("rmid_mul_a", 32'(bus.mul_a), 0);
    chk("rmid_mul_b", 32'(bus.mul_b), 0);
    chk("rmid_rsp_z", 32'(bus.rsp_z), 0);
    step(); #1;
    chk("rmid_no_rsp", 32'(bus.rsp_valid), 0);
    step();
    bus.req_valid = 4'b1001;
    bus.req_a = 16'h9006; bus.req_b = 16'h9007;
    #1;
    chk("rmid_ptr0_grant", 32'(bus.req_ready), 1);
    step();
    bus.req_valid = 4'b1000;
    step();
    bus.rsp_ready = 4'b0001;
    #1;
    chk("rmid_after_z", 32'(bus.rsp_z), 'h2A);
    step();
    clr();

    // Wrap on the 3-requester instance.
    step();
    bus3.req_valid = 3'b100;
    bus3.req_a = 12'h200; bus3.req_b = 12'h300;
    #1;
    chk("wrap_grant2", 32'(bus3.req_ready), 4);
    step();
    bus3.req_valid = '0;
    step();
    bus3.rsp_ready = 3'b100;
    #1;
    chk("wrap_z2", 32'(bus3.rsp_z), 6);
    step();
    bus3.rsp_ready = '0;
    bus3.req_valid = 3'b101;
    bus3.req_a = 12'h405; bus3.req_b = 12'h403;
    #1;
    chk("wrap_grant0", 32'(bus3.req_ready), 1);
    step();
    bus3.req_valid = 3'b100;
    step();
    bus3.rsp_ready = 3'b001;
    #1;
    chk("wrap_z0", 32'(bus3.rsp_z), 15);
    step();
    clr();

    // Randomized traffic against a transaction-level model.
    do_reset();
    ptr_m = 0;
    for (int i = 0; i < 4; i++) begin v[i] = 0; ra[i] = '0; rb[i] = '0; end
    for (int txn = 0; txn < 60; txn++) begin
      step();
      for (int i = 0; i < 4; i++) begin
        if (!v[i] && ($urandom % 3 == 0)) begin
          v[i] = 1; ra[i] = 4'($urandom); rb[i] = 4'($urandom);
        end else if (v[i] && ($urandom % 10 == 0)) begin
          v[i] = 0;
        end
        bus.req_valid[i] = v[i];
        bus.req_a[4*i +: 4] = ra[i];
        bus.req_b[4*i +: 4] = rb[i];
      end
      bus.rsp_ready = 4'($urandom);
      #1;
      w = -1;
      for (int k = 0; k < 4; k++)
        if (w < 0 && v[(ptr_m + k) % 4]) w = (ptr_m + k) % 4;
      if (w < 0) begin
        chk("rnd_nogrant", 32'(bus.req_ready), 0);
        continue;
      end
      chk("rnd_grant", 32'(bus.req_ready), 1 << w);
      a_m = int'(ra[w]); b_m = int'(rb[w]);
      v[w] = 0;
      step();
      bus.req_valid[w] = 1'b0;
      bus.rsp_ready = 4'($urandom);
      #1;
      chk("rnd_calc_busy", 32'(bus.busy), 1);
      chk("rnd_calc_rspv", 32'(bus.rsp_valid), 0);
      pending = 1;
      for (int c = 0; c < 20 && pending != 0; c++) begin
        step();
        rr = 4'($urandom);
        if (c == 19) rr[w] = 1'b1;
        bus.rsp_ready = rr;
        #1;
        chk("rnd_rspv", 32'(bus.rsp_valid), 1 << w);
        chk("rnd_rsp_z", 32'(bus.rsp_z), a_m * b_m);
        chk("rnd_req_ready", 32'(bus.req_ready), 0);
        if (rr[w]) pending = 0;
      end
      ptr_m = (w + 1) % 4;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
